shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command-driven controller for the 8-bit load/shift register datapath. It accepts one shift command at a time over a valid/ready handshake and loads the operand into its internal shift register. It then steps the register one position per clock for the requested amount and returns the result with a one-cycle done pulse. It replaces manual KEY-driven load/shift sequencing so that upstream logic can issue shift operations directly.

## Interface
- WIDTH, 8, shift register width in bits
- AMT_W, 4, shift-amount width; amounts 0..2^AMT_W-1

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_data  in  WIDTH  operand to load
- cmd_amt  in  AMT_W  number of single-bit shift steps
- cmd_mode  in  2  operation: 00 logical right, 01 arithmetic right, 10 rotate right, 11 logical left
- abort  in  1  cancel the operation in progress
- busy  out  1  high in SHIFT and DONE
- shift_en  out  1  high in any cycle whose closing edge performs a shift
- q  out  WIDTH  live shift register contents
- result  out  WIDTH  last completed result; held until next completion
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at an edge: q<=cmd_data, count<=cmd_amt, mode latched, state<=SHIFT. While not in IDLE, cmd_valid is ignored and cmd_ready=0.
- SHIFT with count!=0: shift_en=1; at the edge, q is shifted one bit per the latched mode and count<=count-1.
- SHIFT with count==0: at the edge, result<=q and state<=DONE. No shift occurs.
- DONE: done=1 for exactly one cycle, then state<=IDLE.
- Shift rules: LSR inserts 0 at MSB. ASR replicates q[WIDTH-1]. ROR moves q[0] into the MSB. LSL inserts 0 at LSB.
- Amounts of WIDTH or more are not saturated. All steps execute, so a logical shift ends at 0 and a rotate wraps modulo WIDTH.
- cmd_mode and cmd_data changes after acceptance have no effect.
- abort=1 in SHIFT: state<=IDLE at the next edge with no shift on that edge. q keeps its partially shifted value, result is unchanged, and no done pulse is produced. abort has priority over shifting and over the count==0 completion. It is ignored in IDLE and DONE.
- Reset (any time, including mid-operation): state=IDLE, q=0, result=0, count=0, mode=00. Outputs: done=0, busy=0, shift_en=0, cmd_ready=1.

## Timing
- Command accepted at edge k with amount N:
  - Shifts occur at edges k+1..k+N.
  - result is updated at edge k+N+1; done is high in the cycle after edge k+N+1.
  - cmd_ready returns high after edge k+N+2.
- Minimum command spacing is N+3 cycles. Back-to-back acceptance is possible in the first IDLE cycle.
- cmd_ready, busy, done and shift_en are decoded combinationally from state and count. There is no combinational path from cmd_valid to cmd_ready.
- q changes only at clock edges or on reset assertion.

## Configuration
- SHIFT_ROTATE_EN defined: mode 10 performs rotate right as described.
- SHIFT_ROTATE_EN undefined: rotate logic is not compiled. Mode 10 behaves exactly as mode 00 (logical right). All other modes are unchanged.

## Test plan
- Reset: apply reset low with all inputs idle, then release.
  - During reset: q=0x00, result=0x00, cmd_ready=1, done=0, busy=0.
  - Assert reset mid-operation (cmd_data 0xA5, amt 5, mode 00, after 2 shifts). Immediately q=0x00, busy=0, and no done pulse follows.
- LSR/ASR:
  - cmd_data 0xB4, amt 3, mode 00: result=0x16, done high 4 cycles after the acceptance edge, shift_en high for exactly 3 cycles.
  - Then cmd_data 0x90, amt 2, mode 01: result=0xE4.
- LSL and amount zero:
  - cmd_data 0x0F, amt 4, mode 11: result=0xF0.
  - cmd_data 0x5A, amt 0: result=0x5A, done in the cycle after edge k+1, shift_en never asserted.
- Rotate configuration, cmd_data 0x81, amt 1, mode 10:
  - With SHIFT_ROTATE_EN: result=0xC0.
  - Without it: result=0x40.
  - With the macro, cmd_data 0x81, amt 9: result=0xC0 (wraps).
- Abort:
  - Start cmd_data 0xFF, amt 6, mode 11 after a prior result of 0x16. Assert abort in the cycle after the 2nd shift.
  - Required: q=0xFC, result stays 0x16, done never pulses, cmd_ready high the next cycle.
  - A new command is accepted normally.
- Handshake:
  - Hold cmd_valid high continuously with changing cmd_data. Only one command is accepted per operation, each one in the IDLE cycle following a done.
  - Toggling cmd_mode mid-operation does not alter the result.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven load/shift controller for a WIDTH-bit register.
// Optional rotate-right mode (10) is compiled only when SHIFT_ROTATE_EN is defined.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    input  logic [1:0]       cmd_mode_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             shift_en_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_step;

    // One single-bit step of the register according to the latched mode
    always_comb begin
        q_step = q_q;
        unique case (mode_q)
            2'b00: q_step = {1'b0, q_q[WIDTH-1:1]};
            2'b01: q_step = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            2'b10: q_step = {q_q[0], q_q[WIDTH-1:1]};
`else
            2'b10: q_step = {1'b0, q_q[WIDTH-1:1]};
`endif
            2'b11: q_step = {q_q[WIDTH-2:0], 1'b0};
            default: q_step = q_q;
        endcase
    end

    // Next-state logic: accept, step, complete or abort
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        result_d = result_q;
        count_d  = count_q;
        mode_d   = mode_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    q_d     = cmd_data_i;
                    count_d = cmd_amt_i;
                    mode_d  = cmd_mode_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    q_d     = q_step;
                    count_d = count_q - ONE;
                end else begin
                    result_d = q_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            q_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
            mode_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            result_q <= result_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == SHIFT) || (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign shift_en_o  = (state_q == SHIFT) && (count_q != '0) && !abort_i;
    assign q_o         = q_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed self-checking bench for shift_sequencer.
// Expected values are hand-computed; rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [3:0] cmd_amt;
    logic [1:0] cmd_mode;
    logic       abort;
    logic       busy;
    logic       shift_en;
    logic [7:0] q;
    logic [7:0] result;
    logic       done;

    int n_cmp;
    int n_bad;

    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_data_i  (cmd_data),
        .cmd_amt_i   (cmd_amt),
        .cmd_mode_i  (cmd_mode),
        .abort_i     (abort),
        .busy_o      (busy),
        .shift_en_o  (shift_en),
        .q_o         (q),
        .result_o    (result),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command and follow it to its done pulse.
    // done_idx counts negedges after the acceptance edge (0 = first one).
    task automatic run_cmd(input logic [7:0] d, input logic [3:0] a,
                           input logic [1:0] m, output logic [7:0] res,
                           output int done_idx, output int sh);
        int n;
        res = 8'hxx;
        done_idx = -1;
        sh = 0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_data = d;
        cmd_amt = a;
        cmd_mode = m;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (shift_en) sh++;
            if (done) begin
                done_idx = i;
                res = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = 8'h00;
        cmd_amt = 4'd0;
        cmd_mode = 2'b00;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (q !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_q: got %h want 00", q);
        end
        n_cmp++;
        if (result !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 00", result);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (shift_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_shift_en: got %b want 0", shift_en);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lsr_asr;
        logic [7:0] r;
        int di, sh;
        run_cmd(8'hB4, 4'd3, 2'b00, r, di, sh);
        n_cmp++;
        if (r !== 8'h16) begin
            n_bad++;
            $display("FAIL lsr_result: got %h want 16", r);
        end
        n_cmp++;
        if (di !== 4) begin
            n_bad++;
            $display("FAIL lsr_done_cycle: got %0d want 4", di);
        end
        n_cmp++;
        if (sh !== 3) begin
            n_bad++;
            $display("FAIL lsr_shift_en_count: got %0d want 3", sh);
        end
        run_cmd(8'h90, 4'd2, 2'b01, r, di, sh);
        n_cmp++;
        if (r !== 8'hE4) begin
            n_bad++;
            $display("FAIL asr_result: got %h want e4", r);
        end
    endtask

    task automatic test_lsl_zero;
        logic [7:0] r;
        int di, sh;
        run_cmd(8'h0F, 4'd4, 2'b11, r, di, sh);
        n_cmp++;
        if (r !== 8'hF0) begin
            n_bad++;
            $display("FAIL lsl_result: got %h want f0", r);
        end
        run_cmd(8'h5A, 4'd0, 2'b00, r, di, sh);
        n_cmp++;
        if (r !== 8'h5A) begin
            n_bad++;
            $display("FAIL zero_result: got %h want 5a", r);
        end
        n_cmp++;
        if (di !== 1) begin
            n_bad++;
            $display("FAIL zero_done_cycle: got %0d want 1", di);
        end
        n_cmp++;
        if (sh !== 0) begin
            n_bad++;
            $display("FAIL zero_shift_en_count: got %0d want 0", sh);
        end
        run_cmd(8'h01, 4'd12, 2'b00, r, di, sh);
        n_cmp++;
        if (r !== 8'h00) begin
            n_bad++;
            $display("FAIL lsr_over_width: got %h want 00", r);
        end
    endtask

    task automatic test_rotate;
        logic [7:0] r;
        logic [7:0] e1, e9;
        int di, sh;
`ifdef SHIFT_ROTATE_EN
        e1 = 8'hC0;
        e9 = 8'hC0;
`else
        e1 = 8'h40;
        e9 = 8'h00;
`endif
        run_cmd(8'h81, 4'd1, 2'b10, r, di, sh);
        n_cmp++;
        if (r !== e1) begin
            n_bad++;
            $display("FAIL rot1_result: got %h want %h", r, e1);
        end
        run_cmd(8'h81, 4'd9, 2'b10, r, di, sh);
        n_cmp++;
        if (r !== e9) begin
            n_bad++;
            $display("FAIL rot9_result: got %h want %h", r, e9);
        end
    endtask

    task automatic test_abort;
        logic [7:0] r;
        int di, sh;
        int seen_done;
        run_cmd(8'hB4, 4'd3, 2'b00, r, di, sh);
        seen_done = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 8'hFF;
        cmd_amt = 4'd6;
        cmd_mode = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (done) seen_done++;
        @(negedge clk);
        if (done) seen_done++;
        @(negedge clk);
        if (done) seen_done++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (q !== 8'hFC) begin
            n_bad++;
            $display("FAIL abort_q: got %h want fc", q);
        end
        n_cmp++;
        if (result !== 8'h16) begin
            n_bad++;
            $display("FAIL abort_result: got %h want 16", result);
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready: got %b want 1", cmd_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", seen_done);
        end
        run_cmd(8'h3C, 4'd1, 2'b00, r, di, sh);
        n_cmp++;
        if (r !== 8'h1E) begin
            n_bad++;
            $display("FAIL abort_next_cmd: got %h want 1e", r);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        logic [7:0] r;
        logic prev_done;
        int accepts;
        int bad_slot;
        int bad_res;
        exp = 8'h00;
        r = 8'hxx;
        prev_done = 1'b0;
        accepts = 0;
        bad_slot = 0;
        bad_res = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_amt = 4'd1;
        cmd_mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            cmd_data = 8'(8'h20 + i * 7);
            if (done && result !== exp) bad_res++;
            if (cmd_ready) begin
                accepts++;
                exp = cmd_data >> 1;
                if (i != 0 && !prev_done) bad_slot++;
            end
            prev_done = done;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (accepts !== 5) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d want 5", accepts);
        end
        n_cmp++;
        if (bad_slot !== 0) begin
            n_bad++;
            $display("FAIL b2b_accept_slot: got %0d misplaced want 0", bad_slot);
        end
        n_cmp++;
        if (bad_res !== 0) begin
            n_bad++;
            $display("FAIL b2b_results: got %0d wrong want 0", bad_res);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 8'hC3;
        cmd_amt = 4'd3;
        cmd_mode = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmd_mode = 2'(i);
            cmd_data = 8'($urandom);
            if (done) begin
                r = result;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (r !== 8'hF8) begin
            n_bad++;
            $display("FAIL mode_toggle_result: got %h want f8", r);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 8'hA5;
        cmd_amt = 4'd5;
        cmd_mode = 2'b00;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q !== 8'h29) begin
            n_bad++;
            $display("FAIL mid_q_before: got %h want 29", q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset_q: got %h want 00", q);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (result !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset_result: got %h want 00", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_no_done: got %0d pulses want 0", seen_done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lsr_asr();
        test_lsl_zero();
        test_rotate();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
